fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Parametrised instruction-sequencing unit for the ARMv4 core. It replaces the fixed 4-phase reset/fetch/decode/exec counter and the free-running program-counter increment.
- Drives program-memory reads with a configurable read latency.
- Presents each fetched instruction to decode/execute through a valid/ready handshake.
- Waits for execute completion, then advances the PC sequentially or loads a branch target.

Parameters:
- PC_WIDTH, 8, program-counter and memory-address width.
- INSTR_WIDTH, 32, instruction width.
- MEM_LATENCY, 1, program-memory read latency in cycles (legal range 1..4).
- RESET_PC, 0, PC value after reset.
- PC_STEP, 1, sequential PC increment (1 = word-addressed memory).

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  reset, synchronous, active-low.
- run  input  1  enables sequencing. Sampled only in IDLE and at EXEC exit.
- imem_req  output  1  one-cycle program-memory read strobe.
- imem_addr  output  PC_WIDTH  read address, equal to pc.
- imem_rdata  input  INSTR_WIDTH  read data, valid in the MEM_LATENCY-th cycle after imem_req.
- instr_valid  output  1  a fetched instruction is offered.
- instr  output  INSTR_WIDTH  fetched instruction.
- instr_pc  output  PC_WIDTH  address of instr.
- instr_ready  input  1  decode/execute accepts instr.
- exec_done  input  1  execute has finished the current instruction.
- branch_taken  input  1  qualifies exec_done: load branch_target.
- branch_target  input  PC_WIDTH  next PC when the branch is taken.
- pc  output  PC_WIDTH  current program counter.
- state  output  3  current FSM state, for debug.

Behaviour:
- All registers update on the CLK rising edge. RST_N=0 at an edge forces reset values on that edge.
- Reset values: state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instr=0, instr_pc=0, wait counter=0.
- Reset mid-operation aborts at the next edge. Any in-flight imem_rdata is discarded.
- FSM encodings: IDLE=0, FETCH=1, WAIT_MEM=2, ISSUE=3, EXEC=4. Codes 5..7 go to IDLE on the next edge.
- IDLE: outputs idle. Go to FETCH when run=1; otherwise stay.
- FETCH (exactly 1 cycle): imem_req=1, imem_addr=pc. Load wait counter with MEM_LATENCY. Go to WAIT_MEM.
- WAIT_MEM: imem_req=0. Decrement the counter each cycle. In the cycle the counter equals 1:
  - capture imem_rdata into instr and pc into instr_pc at the edge;
  - go to ISSUE.
- WAIT_MEM lasts exactly MEM_LATENCY cycles.
- ISSUE: instr_valid=1. instr and instr_pc stay stable while instr_valid=1.
  - Handshake occurs when instr_valid && instr_ready at an edge; then go to EXEC, with instr_valid=0 from the next cycle.
  - If instr_ready=1 on the first ISSUE cycle, ISSUE lasts 1 cycle.
- EXEC: wait for exec_done=1.
  - On that edge: pc <= branch_taken ? branch_target : pc+PC_STEP, truncated to PC_WIDTH (wrap-around; e.g. 8'hFF+1 = 8'h00).
  - Next state is FETCH if run=1, else IDLE.
- exec_done, branch_taken and branch_target are ignored outside EXEC. branch_taken is ignored without exec_done.
- instr_ready is ignored outside ISSUE.
- Deasserting run mid-instruction does not abort: the current instruction completes, then the FSM parks in IDLE.
- The PC changes only at EXEC exit and at reset.
- Minimum cycles per instruction = 3 + MEM_LATENCY (FETCH + WAIT_MEM + ISSUE + EXEC, each at minimum length).
- imem_addr always equals pc (combinational).

Decomposition:
- Shared package holds the state encodings (ST_IDLE..ST_EXEC, 3-bit) and the state width constant, for the debug/trace logic.
- Natural sub-module: pc_unit (PC register with synchronous reset to RESET_PC, load, increment by PC_STEP, truncation).
- FSM, wait counter and instruction register stay in fetch_sequencer.

Test Plan:
- Reset then run: PC_WIDTH=8, MEM_LATENCY=1, run=1, instr_ready=1, exec_done one cycle after EXEC entry, memory word n = 32'hE000_0000+n.
  - imem_req pulses every 5 cycles at addr 0,1,2.
  - instr_pc/instr = 0/E0000000, 1/E0000001.
- Latency sweep: MEM_LATENCY=3, same program -> instr captured exactly 3 cycles after imem_req, 7 cycles per instruction.
- Backpressure: instr_ready held 0 for 4 cycles in ISSUE -> instr_valid stays 1, instr and instr_pc stable, no new imem_req; transfer occurs on the first ready cycle.
- Branch: at pc=8'h05 assert exec_done with branch_taken=1, branch_target=8'h40 -> next imem_addr=8'h40. With branch_taken=1 but exec_done=0, pc is unchanged.
- Wrap and stop: pc=8'hFF, sequential exec_done -> pc=8'h00. With run=0 at that edge, the FSM enters IDLE and no imem_req occurs until run=1.
- Reset mid-fetch: RST_N=0 during WAIT_MEM -> next cycle state=IDLE, pc=RESET_PC, instr_valid=0. Late imem_rdata is not captured.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer_pkg
// Description : State encodings and widths shared by the fetch sequencer and
//               its debug/trace consumers.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_sequencer_pkg;

   localparam int STATE_W = 3;
   localparam int CNT_W   = 3;

   typedef logic [STATE_W-1:0] state_t;

   localparam state_t ST_IDLE     = 3'd0;
   localparam state_t ST_FETCH    = 3'd1;
   localparam state_t ST_WAIT_MEM = 3'd2;
   localparam state_t ST_ISSUE    = 3'd3;
   localparam state_t ST_EXEC     = 3'd4;

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer_pc_unit
// Description : Program counter with synchronous reset, branch load and
//               wrapping sequential increment.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer_pc_unit #(
   parameter int PC_WIDTH = 8,
   parameter int RESET_PC = 0,
   parameter int PC_STEP  = 1
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic                load_i,
   input  logic                advance_i,
   input  logic [PC_WIDTH-1:0] target_i,
   output logic [PC_WIDTH-1:0] pc_o
);

   localparam logic [PC_WIDTH-1:0] c_RESET_PC = PC_WIDTH'(RESET_PC);
   localparam logic [PC_WIDTH-1:0] c_STEP     = PC_WIDTH'(PC_STEP);

   logic [PC_WIDTH-1:0] pc_q;
   logic [PC_WIDTH-1:0] pc_d;

   // Addition is at PC_WIDTH so the increment wraps naturally.
   always_comb begin
      pc_d = pc_q;
      if (load_i) begin
         pc_d = target_i;
      end else if (advance_i) begin
         pc_d = pc_q + c_STEP;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         pc_q <= c_RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Fetch / wait-memory / issue / execute sequencer driving
//               program-memory reads and a valid/ready instruction handoff.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int PC_WIDTH    = 8,
   parameter int INSTR_WIDTH = 32,
   parameter int MEM_LATENCY = 1,
   parameter int RESET_PC    = 0,
   parameter int PC_STEP     = 1
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic                   run,
   output logic                   imem_req,
   output logic [PC_WIDTH-1:0]    imem_addr,
   input  logic [INSTR_WIDTH-1:0] imem_rdata,
   output logic                   instr_valid,
   output logic [INSTR_WIDTH-1:0] instr,
   output logic [PC_WIDTH-1:0]    instr_pc,
   input  logic                   instr_ready,
   input  logic                   exec_done,
   input  logic                   branch_taken,
   input  logic [PC_WIDTH-1:0]    branch_target,
   output logic [PC_WIDTH-1:0]    pc,
   output logic [STATE_W-1:0]     state
);

   localparam logic [CNT_W-1:0] c_LATENCY = CNT_W'(MEM_LATENCY);

   state_t                 state_q;
   state_t                 state_d;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_d;
   logic [INSTR_WIDTH-1:0] instr_q;
   logic [INSTR_WIDTH-1:0] instr_d;
   logic [PC_WIDTH-1:0]    instr_pc_q;
   logic [PC_WIDTH-1:0]    instr_pc_d;
   logic                   pc_load;
   logic                   pc_advance;
   logic                   capture;
   logic [PC_WIDTH-1:0]    pc_w;

   fetch_sequencer_pc_unit #(
      .PC_WIDTH (PC_WIDTH),
      .RESET_PC (RESET_PC),
      .PC_STEP  (PC_STEP)
   ) u_pc_unit (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .load_i    (pc_load),
      .advance_i (pc_advance),
      .target_i  (branch_target),
      .pc_o      (pc_w)
   );

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:     if (run) state_d = ST_FETCH;
         ST_FETCH:    state_d = ST_WAIT_MEM;
         ST_WAIT_MEM: if (cnt_q == 3'd1) state_d = ST_ISSUE;
         ST_ISSUE:    if (instr_ready) state_d = ST_EXEC;
         ST_EXEC:     if (exec_done) state_d = run ? ST_FETCH : ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      imem_req    = (state_q == ST_FETCH);
      instr_valid = (state_q == ST_ISSUE);
      pc_load     = (state_q == ST_EXEC) && exec_done && branch_taken;
      pc_advance  = (state_q == ST_EXEC) && exec_done && !branch_taken;
      capture     = (state_q == ST_WAIT_MEM) && (cnt_q == 3'd1);
   end

   // Counter is loaded in FETCH so the last WAIT_MEM cycle sees a value of 1.
   always_comb begin
      cnt_d      = cnt_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      if (state_q == ST_FETCH) begin
         cnt_d = c_LATENCY;
      end else if (state_q == ST_WAIT_MEM) begin
         cnt_d = cnt_q - 3'd1;
      end
      if (capture) begin
         instr_d    = imem_rdata;
         instr_pc_d = pc_w;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         cnt_q      <= '0;
         instr_q    <= '0;
         instr_pc_q <= '0;
      end else begin
         cnt_q      <= cnt_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
      end
   end

   assign imem_addr = pc_w;
   assign pc        = pc_w;
   assign instr     = instr_q;
   assign instr_pc  = instr_pc_q;
   assign state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Scoreboard bench for fetch_sequencer at read latencies 1 and 3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

   typedef struct packed {
      logic [7:0]  pc;
      logic [31:0] ins;
   } exp_t;

   logic        CLK = 1'b0;
   int          cyc = 0;
   int          checks = 0;
   int          fails = 0;
   exp_t        sb[$];
   exp_t        e;

   // Latency-1 instance
   logic        RST_N = 1'b0, run = 1'b0, instr_ready = 1'b0;
   logic        auto_exec = 1'b1, exec_man = 1'b0, branch_taken = 1'b0;
   logic [7:0]  branch_target = '0;
   logic        imem_req, instr_valid, exec_done;
   logic [7:0]  imem_addr, instr_pc, pc;
   logic [31:0] imem_rdata, instr;
   logic [2:0]  state;
   logic        ex_seen = 1'b0;
   logic [3:0]  pv = '0;
   logic [7:0]  pa [4];

   // Latency-3 instance
   logic        rst3_n = 1'b0, run3 = 1'b0;
   logic        imem_req3, instr_valid3, exec_done3;
   logic [7:0]  imem_addr3, instr_pc3, pc3;
   logic [31:0] imem_rdata3, instr3;
   logic [2:0]  state3;
   logic        ex_seen3 = 1'b0;
   logic [3:0]  pv3 = '0;
   logic [7:0]  pa3 [4];

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   function automatic logic [31:0] mem_word(input logic [7:0] a);
      return 32'hE000_0000 + {24'd0, a};
   endfunction

   // Program memory models: data appears only in the read's latency cycle.
   always @(posedge CLK) begin
      pv  <= {pv[2:0], imem_req};
      pa[0] <= imem_addr;  pa[1] <= pa[0];  pa[2] <= pa[1];  pa[3] <= pa[2];
      pv3 <= {pv3[2:0], imem_req3};
      pa3[0] <= imem_addr3; pa3[1] <= pa3[0]; pa3[2] <= pa3[1]; pa3[3] <= pa3[2];
      ex_seen  <= (state == 3'd4) && !exec_done;
      ex_seen3 <= (state3 == 3'd4) && !exec_done3;
   end
   assign imem_rdata  = pv[0]  ? mem_word(pa[0])  : 32'hDEAD_BEEF;
   assign imem_rdata3 = pv3[2] ? mem_word(pa3[2]) : 32'hDEAD_BEEF;
   assign exec_done   = auto_exec ? ((state == 3'd4) && ex_seen) : exec_man;
   assign exec_done3  = (state3 == 3'd4) && ex_seen3;

   fetch_sequencer #(.PC_WIDTH(8), .INSTR_WIDTH(32), .MEM_LATENCY(1), .RESET_PC(0), .PC_STEP(1)) u_dut (
      .CLK(CLK), .RST_N(RST_N), .run(run), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
      .instr_ready(instr_ready), .exec_done(exec_done), .branch_taken(branch_taken),
      .branch_target(branch_target), .pc(pc), .state(state));

   fetch_sequencer #(.PC_WIDTH(8), .INSTR_WIDTH(32), .MEM_LATENCY(3), .RESET_PC(0), .PC_STEP(1)) u_dut3 (
      .CLK(CLK), .RST_N(rst3_n), .run(run3), .imem_req(imem_req3), .imem_addr(imem_addr3),
      .imem_rdata(imem_rdata3), .instr_valid(instr_valid3), .instr(instr3), .instr_pc(instr_pc3),
      .instr_ready(1'b1), .exec_done(exec_done3), .branch_taken(1'b0),
      .branch_target(8'h00), .pc(pc3), .state(state3));

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (state === s) begin
            ok = 1'b1;
            return;
         end
         tick();
      end
      ok = (state === s);
   endtask

   task automatic test_reset();
      RST_N = 1'b0;
      repeat (3) tick();
      checks++; if (state !== 3'd0) begin fails++; $display("FAIL reset_state got %0d want 0", state); end
      checks++; if (pc !== 8'h00) begin fails++; $display("FAIL reset_pc got %h want 00", pc); end
      checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req got %b want 0", imem_req); end
      checks++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", instr_valid); end
      checks++; if (instr !== 32'h0) begin fails++; $display("FAIL reset_instr got %h want 0", instr); end
      checks++; if (instr_pc !== 8'h00) begin fails++; $display("FAIL reset_instr_pc got %h want 00", instr_pc); end
   endtask

   task automatic test_run();
      int nreq = 0;
      int npop = 0;
      int last = 0;
      bit ok;
      sb.delete();
      for (int n = 0; n < 3; n++) sb.push_back('{pc: 8'(n), ins: mem_word(8'(n))});
      RST_N = 1'b1; run = 1'b1; instr_ready = 1'b1; auto_exec = 1'b1;
      for (int i = 0; i < 40 && npop < 3; i++) begin
         tick();
         if (imem_req) begin
            checks++; if (imem_addr !== 8'(nreq)) begin fails++; $display("FAIL run_addr got %h want %h", imem_addr, 8'(nreq)); end
            if (nreq > 0) begin
               checks++; if (cyc - last != 5) begin fails++; $display("FAIL run_period got %0d want 5", cyc - last); end
            end
            last = cyc;
            nreq++;
         end
         if (instr_valid && instr_ready) begin
            e = sb.pop_front();
            npop++;
            checks++; if (instr_pc !== e.pc || instr !== e.ins) begin
               fails++; $display("FAIL run_instr got %h/%h want %h/%h", instr_pc, instr, e.pc, e.ins);
            end
            if (npop == 3) run = 1'b0;
         end
      end
      checks++; if (npop != 3) begin fails++; $display("FAIL run_timeout got %0d transfers want 3", npop); end
      wait_state(3'd0, 20, ok);
      checks++; if (!ok) begin fails++; $display("FAIL run_park got state %0d want 0", state); end
   endtask

   task automatic test_latency();
      int nreq = 0;
      int npop = 0;
      int last = 0;
      logic prev_v = 1'b0;
      sb.delete();
      for (int n = 0; n < 3; n++) sb.push_back('{pc: 8'(n), ins: mem_word(8'(n))});
      rst3_n = 1'b1; run3 = 1'b1;
      for (int i = 0; i < 60 && npop < 3; i++) begin
         tick();
         if (imem_req3) begin
            if (nreq > 0) begin
               checks++; if (cyc - last != 7) begin fails++; $display("FAIL lat_period got %0d want 7", cyc - last); end
            end
            last = cyc;
            nreq++;
         end
         if (instr_valid3 && !prev_v) begin
            checks++; if (cyc - last != 4) begin fails++; $display("FAIL lat_capture got %0d want 4", cyc - last); end
            e = sb.pop_front();
            npop++;
            checks++; if (instr_pc3 !== e.pc || instr3 !== e.ins) begin
               fails++; $display("FAIL lat_instr got %h/%h want %h/%h", instr_pc3, instr3, e.pc, e.ins);
            end
            if (npop == 3) run3 = 1'b0;
         end
         prev_v = instr_valid3;
      end
      checks++; if (npop != 3) begin fails++; $display("FAIL lat_timeout got %0d transfers want 3", npop); end
   endtask

   task automatic test_backpressure();
      bit ok;
      RST_N = 1'b0; tick();
      sb.delete();
      sb.push_back('{pc: 8'h00, ins: mem_word(8'h00)});
      RST_N = 1'b1; run = 1'b1; instr_ready = 1'b0; auto_exec = 1'b1;
      wait_state(3'd3, 10, ok);
      checks++; if (!ok) begin fails++; $display("FAIL bp_reach_issue got state %0d want 3", state); end
      for (int k = 0; k < 4; k++) begin
         checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== sb[0].ins || instr_pc !== sb[0].pc) begin
            fails++; $display("FAIL bp_hold got v=%b req=%b %h/%h want v=1 req=0 %h/%h",
                              instr_valid, imem_req, instr_pc, instr, sb[0].pc, sb[0].ins);
         end
         tick();
      end
      instr_ready = 1'b1; run = 1'b0;
      e = sb.pop_front();
      checks++; if (instr_valid !== 1'b1 || instr !== e.ins || instr_pc !== e.pc) begin
         fails++; $display("FAIL bp_xfer got v=%b %h/%h want v=1 %h/%h", instr_valid, instr_pc, instr, e.pc, e.ins);
      end
      tick();
      checks++; if (state !== 3'd4 || instr_valid !== 1'b0) begin
         fails++; $display("FAIL bp_exec got state %0d v=%b want 4 v=0", state, instr_valid);
      end
      wait_state(3'd0, 10, ok);
      checks++; if (!ok) begin fails++; $display("FAIL bp_park got state %0d want 0", state); end
   endtask

   task automatic test_branch();
      bit ok;
      RST_N = 1'b0; tick();
      RST_N = 1'b1; run = 1'b1; instr_ready = 1'b1; auto_exec = 1'b0; exec_man = 1'b0;
      wait_state(3'd4, 10, ok);
      checks++; if (!ok) begin fails++; $display("FAIL br_reach_exec got state %0d want 4", state); end
      exec_man = 1'b1; branch_taken = 1'b1; branch_target = 8'h05;
      tick();
      exec_man = 1'b0; branch_taken = 1'b0;
      checks++; if (pc !== 8'h05 || state !== 3'd1 || imem_addr !== 8'h05) begin
         fails++; $display("FAIL br_to5 got pc=%h st=%0d addr=%h want 05/1/05", pc, state, imem_addr);
      end
      wait_state(3'd4, 10, ok);
      branch_taken = 1'b1; branch_target = 8'h40;
      for (int k = 0; k < 2; k++) begin
         tick();
         checks++; if (pc !== 8'h05 || state !== 3'd4) begin
            fails++; $display("FAIL br_no_done got pc=%h st=%0d want 05/4", pc, state);
         end
      end
      sb.delete();
      sb.push_back('{pc: 8'h40, ins: mem_word(8'h40)});
      exec_man = 1'b1;
      tick();
      exec_man = 1'b0; branch_taken = 1'b0;
      checks++; if (pc !== 8'h40 || imem_req !== 1'b1 || imem_addr !== 8'h40) begin
         fails++; $display("FAIL br_taken got pc=%h req=%b addr=%h want 40/1/40", pc, imem_req, imem_addr);
      end
      wait_state(3'd3, 10, ok);
      e = sb.pop_front();
      checks++; if (!ok || instr_pc !== e.pc || instr !== e.ins) begin
         fails++; $display("FAIL br_instr got %h/%h want %h/%h", instr_pc, instr, e.pc, e.ins);
      end
   endtask

   task automatic test_wrap_stop();
      bit ok;
      wait_state(3'd4, 10, ok);
      exec_man = 1'b1; branch_taken = 1'b1; branch_target = 8'hFF;
      tick();
      exec_man = 1'b0; branch_taken = 1'b0;
      wait_state(3'd4, 10, ok);
      checks++; if (!ok || pc !== 8'hFF || instr !== mem_word(8'hFF)) begin
         fails++; $display("FAIL wrap_setup got pc=%h instr=%h want FF/%h", pc, instr, mem_word(8'hFF));
      end
      run = 1'b0; exec_man = 1'b1;
      tick();
      exec_man = 1'b0;
      checks++; if (pc !== 8'h00 || state !== 3'd0) begin
         fails++; $display("FAIL wrap_pc got pc=%h st=%0d want 00/0", pc, state);
      end
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++; if (imem_req !== 1'b0 || state !== 3'd0) begin
            fails++; $display("FAIL stop_idle got req=%b st=%0d want 0/0", imem_req, state);
         end
      end
      run = 1'b1;
      tick();
      checks++; if (state !== 3'd1 || imem_req !== 1'b1 || imem_addr !== 8'h00) begin
         fails++; $display("FAIL restart got st=%0d req=%b addr=%h want 1/1/00", state, imem_req, imem_addr);
      end
   endtask

   task automatic test_reset_mid_fetch();
      tick();
      checks++; if (state !== 3'd2) begin fails++; $display("FAIL mid_wait got st=%0d want 2", state); end
      RST_N = 1'b0;
      tick();
      RST_N = 1'b1; run = 1'b0;
      checks++; if (state !== 3'd0 || pc !== 8'h00 || instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 8'h00) begin
         fails++; $display("FAIL mid_reset got st=%0d pc=%h v=%b %h/%h want 0/00/0 00/0",
                           state, pc, instr_valid, instr_pc, instr);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (instr !== 32'h0 || state !== 3'd0) begin
            fails++; $display("FAIL mid_discard got instr=%h st=%0d want 0/0", instr, state);
         end
      end
   endtask

   initial begin
      tick();
      test_reset();
      test_run();
      test_latency();
      test_backpressure();
      test_branch();
      test_wrap_stop();
      test_reset_mid_fetch();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
`default_nettype wire
